// File: rtl/dc_writeback.sv
// Write-back engine for a four-slot data cache: tracks dirty slots and drains
// them to memory one word at a time on flush requests.
module dc_writeback #(
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [3:0][WORD_WIDTH-1:0] dc_vals,
  input  logic [3:0][ADDR_WIDTH-1:0] dc_addrs,
  input  logic                       dc_write,
  input  logic [1:0]                 dc_write_sel,
  input  logic                       dc_reload,
  input  logic [1:0]                 dc_mutate,
  input  logic                       dc_flush,
  input  logic [1:0]                 dc_flush_sel,
  input  logic                       dc_flush_all,
  output logic                       mem_write,
  output logic [ADDR_WIDTH-1:0]      mem_addr,
  output logic [WORD_WIDTH-1:0]      mem_out,
  input  logic                       mem_write_ack,
  output logic [3:0]                 dirty,
  output logic                       busy,
  output logic                       flush_done
);

  typedef enum logic [1:0] {IDLE, SELECT, WRITE} state_t;

  state_t                state, state_next;
  logic [3:0]            pending, pending_next, dirty_next;
  logic [1:0]            slot, slot_next, pick;
  logic                  rewrite, rewrite_next;
  logic                  mem_write_next, busy_next, flush_done_next;
  logic [ADDR_WIDTH-1:0] mem_addr_next;
  logic [WORD_WIDTH-1:0] mem_out_next;
  logic                  found, accept, write_hits_slot;

  assign accept          = (state == WRITE) && mem_write && mem_write_ack;
  assign write_hits_slot = dc_write && (dc_write_sel == slot);

  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (pending[i] && !found) begin
        pick  = 2'(i);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_next      = state;
    pending_next    = pending;
    slot_next       = slot;
    rewrite_next    = rewrite;
    mem_write_next  = mem_write;
    mem_addr_next   = mem_addr;
    mem_out_next    = mem_out;
    flush_done_next = 1'b0;

    // Later assignments take priority: a same-cycle core write always re-dirties.
    dirty_next = dirty;
    if (accept && !rewrite && !write_hits_slot) dirty_next[slot] = 1'b0;
    if (dc_reload) dirty_next[dc_mutate] = 1'b0;
    if (dc_write) dirty_next[dc_write_sel] = 1'b1;

    case (state)
      IDLE: begin
        if (dc_flush_all) begin
          pending_next = dirty;
          state_next   = SELECT;
        end else if (dc_flush) begin
          pending_next = dirty & (4'b0001 << dc_flush_sel);
          state_next   = SELECT;
        end
      end
      SELECT: begin
        if (pending == '0) begin
          flush_done_next = 1'b1;
          state_next      = IDLE;
        end else begin
          slot_next           = pick;
          mem_addr_next       = dc_addrs[pick];
          mem_out_next        = dc_vals[pick];
          pending_next[pick]  = 1'b0;
          rewrite_next        = dc_write && (dc_write_sel == pick);
          mem_write_next      = 1'b1;
          state_next          = WRITE;
        end
      end
      WRITE: begin
        if (write_hits_slot) rewrite_next = 1'b1;
        if (accept) begin
          mem_write_next = 1'b0;
          state_next     = SELECT;
        end
      end
      default: state_next = IDLE;
    endcase

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pending    <= '0;
      slot       <= '0;
      rewrite    <= 1'b0;
      dirty      <= '0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_out    <= '0;
      busy       <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      state      <= state_next;
      pending    <= pending_next;
      slot       <= slot_next;
      rewrite    <= rewrite_next;
      dirty      <= dirty_next;
      mem_write  <= mem_write_next;
      mem_addr   <= mem_addr_next;
      mem_out    <= mem_out_next;
      busy       <= busy_next;
      flush_done <= flush_done_next;
    end
  end

endmodule

// File: tb/tb_dc_writeback.sv
// Directed bench for dc_writeback: expected memory writes are queued by the
// stimulus and checked by a monitor whenever mem_write is presented.
module tb_dc_writeback;

  logic              clk = 1'b0;
  logic              reset;
  logic [3:0][31:0]  dc_vals;
  logic [3:0][31:0]  dc_addrs;
  logic              dc_write;
  logic [1:0]        dc_write_sel;
  logic              dc_reload;
  logic [1:0]        dc_mutate;
  logic              dc_flush;
  logic [1:0]        dc_flush_sel;
  logic              dc_flush_all;
  logic              mem_write;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_out;
  logic              mem_write_ack;
  logic [3:0]        dirty;
  logic              busy;
  logic              flush_done;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  int exp_done = 0;
  int hi_cycles = 0;
  logic [63:0] exp_q[$];

  dc_writeback #(.WORD_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .dc_vals(dc_vals), .dc_addrs(dc_addrs),
    .dc_write(dc_write), .dc_write_sel(dc_write_sel),
    .dc_reload(dc_reload), .dc_mutate(dc_mutate),
    .dc_flush(dc_flush), .dc_flush_sel(dc_flush_sel), .dc_flush_all(dc_flush_all),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_out(mem_out),
    .mem_write_ack(mem_write_ack),
    .dirty(dirty), .busy(busy), .flush_done(flush_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [1:0] s);
    dc_write = 1'b1;
    dc_write_sel = s;
    tick();
    dc_write = 1'b0;
  endtask

  task automatic push_slot(input int s);
    exp_q.push_back({dc_addrs[s], dc_vals[s]});
  endtask

  task automatic wait_done(input int max);
    int start;
    int n;
    start = done_seen;
    n = 0;
    while (done_seen == start && n < max) begin
      tick();
      n++;
    end
    chk("flush_done_timeout", 64'(done_seen > start), 64'd1);
    tick();
  endtask

  initial begin
    reset = 1'b1;
    dc_write = 1'b0; dc_write_sel = '0;
    dc_reload = 1'b0; dc_mutate = '0;
    dc_flush = 1'b0; dc_flush_sel = '0; dc_flush_all = 1'b0;
    mem_write_ack = 1'b0;
    dc_addrs[0] = 32'h0000_0040; dc_vals[0] = 32'h1111_0000;
    dc_addrs[1] = 32'h0000_0080; dc_vals[1] = 32'h2222_1111;
    dc_addrs[2] = 32'h0000_0100; dc_vals[2] = 32'hDEAD_BEEF;
    dc_addrs[3] = 32'h0000_01C0; dc_vals[3] = 32'h4444_3333;

    fork
      forever begin
        @(negedge clk);
        if (mem_write === 1'b1) begin
          hi_cycles++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write actual=%h_%h required=none", mem_addr, mem_out);
          end else if ({mem_addr, mem_out} !== exp_q[0]) begin
            errors++;
            $display("FAIL write_payload actual=%h_%h required=%h", mem_addr, mem_out, exp_q[0]);
          end
          if (mem_write_ack && exp_q.size() > 0) void'(exp_q.pop_front());
        end
        if (flush_done === 1'b1) done_seen++;
      end
    join_none

    tick(); tick();
    chk("rst_mem_write", 64'(mem_write), 64'd0);
    chk("rst_dirty", 64'(dirty), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_flush_done", 64'(flush_done), 64'd0);
    chk("rst_addr_data", {mem_addr, mem_out}, 64'd0);
    reset = 1'b0;
    tick();

    // Single flush with ack held high
    mem_write_ack = 1'b1;
    do_write(2'd2);
    chk("t1_dirty_set", 64'(dirty), 64'b0100);
    push_slot(2); exp_done++;
    dc_flush = 1'b1; dc_flush_sel = 2'd2;
    tick();
    dc_flush = 1'b0;
    chk("t1_busy_n1", 64'(busy), 64'd1);
    chk("t1_no_write_n1", 64'(mem_write), 64'd0);
    tick();
    chk("t1_write_n2", 64'(mem_write), 64'd1);
    chk("t1_addr_data_n2", {mem_addr, mem_out}, {32'h100, 32'hDEADBEEF});
    tick();
    chk("t1_write_drop_n3", 64'(mem_write), 64'd0);
    chk("t1_dirty_clear", 64'(dirty), 64'd0);
    tick();
    chk("t1_done_n4", 64'(flush_done), 64'd1);
    chk("t1_idle_n4", 64'(busy), 64'd0);
    tick();
    chk("t1_done_pulse", 64'(flush_done), 64'd0);
    chk("t1_done_count", 64'(done_seen), 64'(exp_done));

    // Ack withheld five cycles; payload must hold even if slot value moves
    mem_write_ack = 1'b0;
    do_write(2'd0);
    push_slot(0); exp_done++;
    dc_flush = 1'b1; dc_flush_sel = 2'd0;
    tick();
    dc_flush = 1'b0;
    tick();
    hi_cycles = 0;
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_write", 64'(mem_write), 64'd1);
      if (i == 1) dc_vals[0] = 32'h9999_9999;
      tick();
    end
    mem_write_ack = 1'b1;
    tick();
    chk("t2_write_drop", 64'(mem_write), 64'd0);
    chk("t2_high_cycles", 64'(hi_cycles), 64'd6);
    chk("t2_dirty_clear", 64'(dirty), 64'd0);
    dc_vals[0] = 32'h1111_0000;
    wait_done(10);
    chk("t2_done_count", 64'(done_seen), 64'(exp_done));

    // flush_all over slots 1 and 3
    do_write(2'd1);
    do_write(2'd3);
    chk("t3_dirty_set", 64'(dirty), 64'b1010);
    push_slot(1); push_slot(3); exp_done++;
    dc_flush_all = 1'b1;
    tick();
    dc_flush_all = 1'b0;
    wait_done(20);
    chk("t3_dirty_clear", 64'(dirty), 64'd0);
    chk("t3_queue_drained", 64'(exp_q.size()), 64'd0);
    chk("t3_done_count", 64'(done_seen), 64'(exp_done));

    // Core rewrites the slot while its old snapshot is in flight
    mem_write_ack = 1'b0;
    do_write(2'd1);
    push_slot(1); exp_done++;
    dc_flush = 1'b1; dc_flush_sel = 2'd1;
    tick();
    dc_flush = 1'b0;
    tick();
    dc_vals[1] = 32'h5555_AAAA;
    dc_write = 1'b1; dc_write_sel = 2'd1;
    tick();
    dc_write = 1'b0;
    mem_write_ack = 1'b1;
    tick();
    chk("t4_write_drop", 64'(mem_write), 64'd0);
    wait_done(10);
    chk("t4_dirty_kept", 64'(dirty), 64'b0010);
    push_slot(1); exp_done++;
    dc_flush = 1'b1; dc_flush_sel = 2'd1;
    tick();
    dc_flush = 1'b0;
    wait_done(10);
    chk("t4_dirty_clear", 64'(dirty), 64'd0);
    chk("t4_done_count", 64'(done_seen), 64'(exp_done));

    // Clean-slot flush, plus a dirty-slot flush issued while busy
    do_write(2'd3);
    exp_done++;
    dc_flush = 1'b1; dc_flush_sel = 2'd0;
    tick();
    dc_flush_sel = 2'd3;
    chk("t5_busy", 64'(busy), 64'd1);
    tick();
    dc_flush = 1'b0;
    chk("t5_done_n2", 64'(flush_done), 64'd1);
    chk("t5_no_write", 64'(mem_write), 64'd0);
    tick(); tick(); tick();
    chk("t5_idle", {62'd0, busy, mem_write}, 64'd0);
    chk("t5_dirty_kept", 64'(dirty), 64'b1000);
    chk("t5_done_count", 64'(done_seen), 64'(exp_done));

    // Reload clears; a same-cycle write to the reloaded slot wins
    dc_reload = 1'b1; dc_mutate = 2'd3;
    tick();
    chk("t5_reload_clear", 64'(dirty), 64'd0);
    dc_mutate = 2'd2; dc_write = 1'b1; dc_write_sel = 2'd2;
    tick();
    dc_write = 1'b0;
    chk("t5_write_wins", 64'(dirty), 64'b0100);
    tick();
    dc_reload = 1'b0;
    chk("t5_reload_only", 64'(dirty), 64'd0);

    // Reset while a write is outstanding
    mem_write_ack = 1'b0;
    do_write(2'd2);
    push_slot(2);
    dc_flush = 1'b1; dc_flush_sel = 2'd2;
    tick();
    dc_flush = 1'b0;
    tick();
    chk("t6_write_before_rst", 64'(mem_write), 64'd1);
    reset = 1'b1;
    mem_write_ack = 1'b1;
    tick();
    chk("t6_rst_mem_write", 64'(mem_write), 64'd0);
    chk("t6_rst_dirty", 64'(dirty), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    exp_q.delete();
    tick(); tick();
    chk("t6_quiet", {62'd0, busy, mem_write}, 64'd0);
    chk("final_done_count", 64'(done_seen), 64'(exp_done));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
